// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation: issue a one-hot selector control, wait for it to settle, then hold the result until it is taken.
// Optional macro ALU_OP_ILLEGAL_CHECK_EN: reject opcodes 12-15 with an error response instead of running them as a NOP.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  output logic        req_ready,
  output logic [11:0] alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_compeq,
  input  logic        alu_compneq,
  input  logic        alu_compless,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t     state;
  logic [3:0] op_q;
  logic [1:0] settle_cnt;

  // Opcodes 12-15 have no selector line, so they map to an all-zero control.
  function automatic logic [11:0] onehot(input logic [3:0] op);
    return (op < 4'd12) ? (12'd1 << op) : 12'd0;
  endfunction

  function automatic logic [1:0] settle_cycles(input logic [3:0] op);
    return ((op == 4'd3) || (op == 4'd4) || (op == 4'd5)) ? 2'd2 : 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= 4'd0;
      settle_cnt <= 2'd0;
      req_ready  <= 1'b1;
      alu_ctrl   <= 12'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      rsp_flags  <= 3'd0;
`ifdef ALU_OP_ILLEGAL_CHECK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            req_ready <= 1'b0;
`ifdef ALU_OP_ILLEGAL_CHECK_EN
            if (req_op >= 4'd12) begin
              state      <= DONE;
              rsp_valid  <= 1'b1;
              rsp_result <= 32'd0;
              rsp_flags  <= 3'd0;
              rsp_err    <= 1'b1;
            end else begin
              state      <= ISSUE;
              alu_ctrl   <= onehot(req_op);
              settle_cnt <= settle_cycles(req_op);
            end
`else
            state      <= ISSUE;
            alu_ctrl   <= onehot(req_op);
            settle_cnt <= settle_cycles(req_op);
`endif
          end
        end

        ISSUE: begin
          // settle_cnt holds the ISSUE cycles remaining, including this one.
          if (settle_cnt == 2'd1) begin
            settle_cnt <= 2'd0;
            alu_ctrl   <= 12'd0;
            rsp_result <= alu_result;
            rsp_flags  <= {alu_compless, alu_compneq, alu_compeq};
            rsp_valid  <= 1'b1;
            state      <= DONE;
`ifdef ALU_OP_ILLEGAL_CHECK_EN
            rsp_err    <= 1'b0;
`endif
          end else begin
            settle_cnt <= settle_cnt - 2'd1;
            alu_ctrl   <= onehot(op_q);
          end
        end

        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          alu_ctrl  <= 12'd0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef ALU_OP_ILLEGAL_CHECK_EN
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed cases with literal expectations, then random traffic against a transaction-timeline model.
// Honours ALU_OP_ILLEGAL_CHECK_EN the same way the design does.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_op;
  logic        req_ready;
  logic [11:0] alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_compeq;
  logic        alu_compneq;
  logic        alu_compless;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        rsp_err;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef ALU_OP_ILLEGAL_CHECK_EN
  localparam bit IllegalCheck = 1'b1;
`else
  localparam bit IllegalCheck = 1'b0;
`endif

  alu_op_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_ready    (req_ready),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_compeq   (alu_compeq),
    .alu_compneq  (alu_compneq),
    .alu_compless (alu_compless),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic v, input logic [3:0] op,
                               input logic [31:0] res, input logic [2:0] fl, input logic rr);
    rst          = r;
    req_valid    = v;
    req_op       = op;
    alu_result   = res;
    alu_compless = fl[2];
    alu_compneq  = fl[1];
    alu_compeq   = fl[0];
    rsp_ready    = rr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-timeline model: an accepted op occupies the selector for len cycles,
  // then its response is pending until a cycle with rsp_ready high.
  bit          m_inflight = 1'b0;
  bit          m_pending  = 1'b0;
  int          m_age      = 0;
  int          m_len      = 0;
  logic [11:0] m_ctrl     = 12'd0;
  logic [31:0] m_res      = 32'd0;
  logic [2:0]  m_flags    = 3'd0;
  logic        m_err      = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_inflight = 1'b0;
      m_pending  = 1'b0;
      m_age      = 0;
      m_ctrl     = 12'd0;
      m_res      = 32'd0;
      m_flags    = 3'd0;
      m_err      = 1'b0;
    end else if (m_pending) begin
      if (rsp_ready) m_pending = 1'b0;
    end else if (m_inflight) begin
      m_age = m_age + 1;
      if (m_age == m_len) begin
        m_res      = alu_result;
        m_flags    = {alu_compless, alu_compneq, alu_compeq};
        m_err      = 1'b0;
        m_pending  = 1'b1;
        m_inflight = 1'b0;
      end
    end else if (req_valid) begin
      if (IllegalCheck && req_op >= 4'd12) begin
        m_pending = 1'b1;
        m_res     = 32'd0;
        m_flags   = 3'd0;
        m_err     = 1'b1;
      end else begin
        m_inflight = 1'b1;
        m_age      = 0;
        m_len      = (req_op >= 4'd3 && req_op <= 4'd5) ? 2 : 1;
        m_ctrl     = (req_op < 4'd12) ? 12'(2 ** int'(req_op)) : 12'd0;
      end
    end
  end

  // Every cycle, away from the active edge, the outputs must match the model.
  always @(negedge clk) begin
    checkOutput("m_req_ready",  32'(req_ready),  32'(!m_inflight && !m_pending));
    checkOutput("m_alu_ctrl",   32'(alu_ctrl),   32'(m_inflight ? m_ctrl : 12'd0));
    checkOutput("m_rsp_valid",  32'(rsp_valid),  32'(m_pending));
    checkOutput("m_rsp_result", rsp_result,      m_res);
    checkOutput("m_rsp_flags",  32'(rsp_flags),  32'(m_flags));
    checkOutput("m_rsp_err",    32'(rsp_err),    32'(m_err));
    checkOutput("m_onehot",     32'($countones(alu_ctrl) <= 1), 32'd1);
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 3'd0, 1'b0);
    @(negedge clk);
    // A request presented together with reset must be dropped.
    applyStimulus(1'b1, 1'b1, 4'd0, 32'hFFFF_FFFF, 3'b111, 1'b0);
    @(negedge clk);
    checkOutput("rst_req_ready",  32'(req_ready),  32'd1);
    checkOutput("rst_alu_ctrl",   32'(alu_ctrl),   32'd0);
    checkOutput("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    checkOutput("rst_rsp_result", rsp_result,      32'd0);
    checkOutput("rst_rsp_flags",  32'(rsp_flags),  32'd0);
    checkOutput("rst_rsp_err",    32'(rsp_err),    32'd0);

    // Add: one ISSUE cycle, response on the following cycle.
    applyStimulus(1'b0, 1'b1, 4'd0, 32'd0, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("add_ctrl",        32'(alu_ctrl),  32'h001);
    checkOutput("add_req_ready",   32'(req_ready), 32'd0);
    checkOutput("add_valid_early", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd9, 32'h0000_0005, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("add_valid",  32'(rsp_valid), 32'd1);
    checkOutput("add_result", rsp_result,     32'h5);
    checkOutput("add_ctrl_0", 32'(alu_ctrl),  32'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("add_idle", 32'(req_ready), 32'd1);

    // srav: two ISSUE cycles, result taken from the second one.
    applyStimulus(1'b0, 1'b1, 4'd5, 32'hDEAD_0001, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("sh_ctrl1",  32'(alu_ctrl),  32'h020);
    checkOutput("sh_valid1", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h1111_1111, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("sh_ctrl2",  32'(alu_ctrl),  32'h020);
    checkOutput("sh_valid2", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h0000_00A0, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("sh_ctrl3",  32'(alu_ctrl),  32'd0);
    checkOutput("sh_valid3", 32'(rsp_valid), 32'd1);
    checkOutput("sh_result", rsp_result,     32'hA0);

    // Backpressure: response held, new requests ignored.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 4'd0, $urandom, 3'($urandom_range(0, 7)), 1'b0);
      @(negedge clk);
      checkOutput("bp_valid",     32'(rsp_valid), 32'd1);
      checkOutput("bp_result",    rsp_result,     32'hA0);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_ctrl",      32'(alu_ctrl),  32'd0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("bp_release_ready", 32'(req_ready), 32'd1);
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);

    // compless, with rsp_ready raised early (must be ignored until rsp_valid).
    applyStimulus(1'b0, 1'b1, 4'd11, 32'd0, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("cmp_ctrl", 32'(alu_ctrl), 32'h800);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h1, 3'b100, 1'b1);
    @(negedge clk);
    checkOutput("cmp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("cmp_flags", 32'(rsp_flags), 32'h4);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("cmp_done", 32'(req_ready), 32'd1);

    // Illegal opcode 14.
    applyStimulus(1'b0, 1'b1, 4'd14, 32'h1234_5678, 3'b111, 1'b0);
    @(negedge clk);
    checkOutput("ill_ctrl",      32'(alu_ctrl),  32'd0);
    checkOutput("ill_req_ready", 32'(req_ready), 32'd0);
`ifdef ALU_OP_ILLEGAL_CHECK_EN
    checkOutput("ill_valid",  32'(rsp_valid), 32'd1);
    checkOutput("ill_err",    32'(rsp_err),   32'd1);
    checkOutput("ill_result", rsp_result,     32'd0);
    checkOutput("ill_flags",  32'(rsp_flags), 32'd0);
`else
    checkOutput("ill_valid_early", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'h1234_5678, 3'b111, 1'b0);
    @(negedge clk);
    checkOutput("ill_ctrl2",  32'(alu_ctrl),  32'd0);
    checkOutput("ill_valid",  32'(rsp_valid), 32'd1);
    checkOutput("ill_err",    32'(rsp_err),   32'd0);
    checkOutput("ill_result", rsp_result,     32'h1234_5678);
`endif
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 3'd0, 1'b1);
    @(negedge clk);
    checkOutput("ill_done", 32'(req_ready), 32'd1);

    // Reset during the first ISSUE cycle of a shift.
    applyStimulus(1'b0, 1'b1, 4'd4, 32'd0, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("rmid_ctrl", 32'(alu_ctrl), 32'h010);
    applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("rmid_ctrl0",  32'(alu_ctrl),  32'd0);
    checkOutput("rmid_valid",  32'(rsp_valid), 32'd0);
    checkOutput("rmid_ready",  32'(req_ready), 32'd1);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom, 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req_valid  input  1  operation request present.
REQ-004 SHALL have port: req_op  input  4  opcode: 0 add, 1 memadd, 2 comp, 3 sllv, 4 srlv, 5 srav, 6 and, 7 xor, 8 diff, 9 compeq, 10 compneq, 11 compless; 12-15 illegal.
REQ-005 SHALL have port: req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 SHALL have port: alu_ctrl  output  12  one-hot control to operation selector; bit i = opcode i.
REQ-007 SHALL have port: alu_result  input  32  selector result bus.
REQ-008 SHALL have port: alu_compeq, alu_compneq, alu_compless  input  1 each  selector compare flags.
REQ-009 SHALL have port: rsp_valid  output  1  response held.
REQ-010 SHALL have port: rsp_ready  input  1  consumer takes response when rsp_valid && rsp_ready.
REQ-011 SHALL have port: rsp_result  output  32  captured result.
REQ-012 SHALL have port: rsp_flags  output  3  captured {compless, compneq, compeq}.
REQ-013 SHALL have port: rsp_err  output  1  illegal opcode indicator.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DONE.
REQ-015 IDLE: req_ready=1, alu_ctrl=0; on accept latch req_op, load settle counter, go ISSUE.
REQ-016 req_ready SHALL be 0 in ISSUE and DONE; no request accepted outside IDLE.
REQ-017 ISSUE: alu_ctrl = one-hot of latched opcode, held stable every ISSUE cycle.
REQ-018 Settle count: 2 ISSUE cycles for opcodes 3-5 (shifts), 1 cycle for all other legal opcodes.
REQ-019 On last ISSUE cycle SHALL register alu_result into rsp_result and flags into rsp_flags, go DONE.
REQ-020 Latency: accept at edge N -> alu_ctrl valid cycle N+1 -> rsp_valid=1 from edge N+2 (shift: N+3).
REQ-021 DONE: rsp_valid=1, alu_ctrl=0, rsp_result/rsp_flags/rsp_err stable until rsp_ready.
REQ-022 On rsp_valid && rsp_ready SHALL go IDLE; next request accepted no earlier than following cycle.
REQ-023 rsp_ready asserted before rsp_valid SHALL have no effect.
REQ-024 alu_ctrl SHALL never have more than one bit set in any cycle.
REQ-025 req_op changes while not accepted SHALL not affect latched opcode.

Reset
REQ-026 rst high at clock edge SHALL force IDLE from any state, including mid-ISSUE or DONE.
REQ-027 Reset values: req_ready=1, alu_ctrl=0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, settle counter=0.
REQ-028 Request presented in same cycle as rst SHALL be dropped.

Configuration
REQ-029 Macro ALU_OP_ILLEGAL_CHECK_EN SHALL control illegal-opcode handling.
REQ-030 Defined: opcode 12-15 accepted, goes IDLE->DONE directly, alu_ctrl stays 0, rsp_result=0, rsp_flags=0, rsp_err=1.
REQ-031 Undefined: opcode 12-15 treated as NOP, one ISSUE cycle with alu_ctrl=0, alu_result captured as-is, rsp_err tied 0.

Verification
REQ-032 Add: req_op=0, alu_result=0x0000_0005 -> alu_ctrl=0x001 for 1 cycle, rsp_valid 2 cycles after accept, rsp_result=0x5.
REQ-033 Shift: req_op=5 -> alu_ctrl=0x020 for exactly 2 cycles, rsp_valid 3 cycles after accept, result captured on 2nd cycle.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> response stable, req_ready=0, new req_valid ignored; rsp_ready=1 -> IDLE next cycle.
REQ-035 Compare: req_op=11, alu_compless=1, others 0 -> rsp_flags=3'b100, alu_ctrl=0x800.
REQ-036 Reset mid-op: rst asserted during 1st shift ISSUE cycle -> next cycle alu_ctrl=0, rsp_valid=0, req_ready=1.
REQ-037 Illegal: req_op=14 with ALU_OP_ILLEGAL_CHECK_EN -> rsp_err=1, rsp_result=0, alu_ctrl never nonzero; without macro -> rsp_err=0, alu_ctrl=0.
